// File: rtl/fixed_alu_arbiter.sv
// Round-robin arbiter sharing one fixed_alu between NUM_REQ Q18.14 requesters.
// Define FIXED_ALU_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (TIMEOUT_CYCLES).
module fixed_alu_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    input  logic [4*NUM_REQ-1:0]    req_op,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [31:0]             rsp_result,
    output logic                    rsp_overflow,
    output logic                    rsp_underflow,
    output logic                    rsp_div_by_zero,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic [31:0]             alu_a,
    output logic [31:0]             alu_b,
    output logic [3:0]              alu_op,
    output logic                    alu_start,
    input  logic [31:0]             alu_result,
    input  logic                    alu_done,
    input  logic                    alu_overflow,
    input  logic                    alu_underflow,
    input  logic                    alu_div_by_zero
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned SumW = IdxW + 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("fixed_alu_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q;
    logic [IdxW-1:0]     rr_ptr_q, grant_q;
    logic [31:0]         alu_a_q, alu_b_q, rsp_result_q;
    logic [3:0]          alu_op_q;
    logic                alu_start_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic                rsp_ovf_q, rsp_udf_q, rsp_dbz_q;

    logic                gnt_found;
    logic [IdxW-1:0]     gnt_idx, rr_next;
    logic [SumW-1:0]     cand_sum;
    logic [31:0]         sel_a, sel_b;
    logic [3:0]          sel_op;

    // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        req_ready = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_sum  = '0;
        if (state_q == StIdle) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cand_sum = {1'b0, rr_ptr_q} + SumW'(i);
                if (cand_sum >= SumW'(NUM_REQ)) cand_sum = cand_sum - SumW'(NUM_REQ);
                if (!gnt_found && req_valid[cand_sum[IdxW-1:0]]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand_sum[IdxW-1:0];
                end
            end
            if (gnt_found) req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IdxW'(i)) begin
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
                sel_op = req_op[4*i +: 4];
            end
        end
    end

    assign rr_next = (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + IdxW'(1);

`ifdef FIXED_ALU_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] wait_cnt_q;
    logic            rsp_tmo_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            alu_start_q  <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_udf_q    <= 1'b0;
            rsp_dbz_q    <= 1'b0;
`ifdef FIXED_ALU_ARB_TIMEOUT_EN
            wait_cnt_q   <= '0;
            rsp_tmo_q    <= 1'b0;
`endif
        end else begin
            alu_start_q <= 1'b0;
            rsp_valid_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (gnt_found) begin
                        alu_a_q     <= sel_a;
                        alu_b_q     <= sel_b;
                        alu_op_q    <= sel_op;
                        grant_q     <= gnt_idx;
                        rr_ptr_q    <= rr_next;
                        alu_start_q <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
`ifdef FIXED_ALU_ARB_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    state_q <= StWait;
                end
                StWait: begin
                    if (alu_done) begin
                        rsp_result_q <= alu_result;
                        rsp_ovf_q    <= alu_overflow;
                        rsp_udf_q    <= alu_underflow;
                        rsp_dbz_q    <= alu_div_by_zero;
                        rsp_valid_q  <= NUM_REQ'(1) << grant_q;
`ifdef FIXED_ALU_ARB_TIMEOUT_EN
                        rsp_tmo_q    <= 1'b0;
`endif
                        state_q      <= StResp;
                    end
`ifdef FIXED_ALU_ARB_TIMEOUT_EN
                    // Count equals the number of WAIT cycles already spent.
                    else if (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_result_q <= '0;
                        rsp_ovf_q    <= 1'b0;
                        rsp_udf_q    <= 1'b0;
                        rsp_dbz_q    <= 1'b0;
                        rsp_tmo_q    <= 1'b1;
                        rsp_valid_q  <= NUM_REQ'(1) << grant_q;
                        state_q      <= StResp;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CntW'(1);
                    end
`endif
                end
                StResp: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy            = (state_q != StIdle);
    assign alu_a           = alu_a_q;
    assign alu_b           = alu_b_q;
    assign alu_op          = alu_op_q;
    assign alu_start       = alu_start_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_result      = rsp_result_q;
    assign rsp_overflow    = rsp_ovf_q;
    assign rsp_underflow   = rsp_udf_q;
    assign rsp_div_by_zero = rsp_dbz_q;
`ifdef FIXED_ALU_ARB_TIMEOUT_EN
    assign rsp_timeout     = rsp_tmo_q;
`else
    assign rsp_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_fixed_alu_arbiter.sv
// Directed bench for fixed_alu_arbiter with a fixed-latency behavioural ALU stub.
module tb_fixed_alu_arbiter;
    localparam int unsigned NumReq        = 4;
    localparam int unsigned TimeoutCycles = 8;
    localparam int unsigned AluLat        = 3;
    localparam logic [3:0] OpAdd = 4'h0, OpSub = 4'h1, OpMul = 4'h2, OpDiv = 4'h3, OpMax = 4'h5;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NumReq-1:0]      req_valid = '0;
    logic [NumReq-1:0]      req_ready;
    logic [32*NumReq-1:0]   req_a = '0;
    logic [32*NumReq-1:0]   req_b = '0;
    logic [4*NumReq-1:0]    req_op = '0;
    logic [NumReq-1:0]      rsp_valid;
    logic [31:0]            rsp_result;
    logic                   rsp_overflow, rsp_underflow, rsp_div_by_zero, rsp_timeout;
    logic                   busy;
    logic [31:0]            alu_a, alu_b, alu_result;
    logic [3:0]             alu_op;
    logic                   alu_start, alu_done, alu_div_by_zero;
    logic                   alu_overflow = 1'b0;
    logic                   alu_underflow = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_rsp    = 0;
    int unsigned cyc;
    logic stub_en    = 1'b1;
    logic force_done = 1'b0;
    logic [AluLat-1:0] start_sr;
    logic [3:0]  exp_gnt [5];
    logic [31:0] exp_res [5];

    fixed_alu_arbiter #(
        .NUM_REQ        (NumReq),
        .TIMEOUT_CYCLES (TimeoutCycles)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_a           (req_a),
        .req_b           (req_b),
        .req_op          (req_op),
        .rsp_valid       (rsp_valid),
        .rsp_result      (rsp_result),
        .rsp_overflow    (rsp_overflow),
        .rsp_underflow   (rsp_underflow),
        .rsp_div_by_zero (rsp_div_by_zero),
        .rsp_timeout     (rsp_timeout),
        .busy            (busy),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_op          (alu_op),
        .alu_start       (alu_start),
        .alu_result      (alu_result),
        .alu_done        (alu_done),
        .alu_overflow    (alu_overflow),
        .alu_underflow   (alu_underflow),
        .alu_div_by_zero (alu_div_by_zero)
    );

    always #5 clk = ~clk;

    // ALU stub: done pulses AluLat cycles after the start cycle; reset discards in-flight work.
    always @(posedge clk) begin
        if (reset) start_sr <= '0;
        else       start_sr <= {start_sr[AluLat-2:0], alu_start};
    end
    assign alu_done = (start_sr[AluLat-1] & stub_en) | force_done;

    longint sa, sb;
    always_comb begin
        sa = longint'($signed(alu_a));
        sb = longint'($signed(alu_b));
        alu_result      = '0;
        alu_div_by_zero = 1'b0;
        case (alu_op)
            OpAdd: alu_result = 32'(sa + sb);
            OpSub: alu_result = 32'(sa - sb);
            OpMul: alu_result = 32'((sa * sb) >>> 14);
            OpDiv: begin
                if (sb == 0) alu_div_by_zero = 1'b1;
                else         alu_result = 32'((sa <<< 14) / sb);
            end
            OpMax: alu_result = (sa > sb) ? alu_a : alu_b;
            default: alu_result = '0;
        endcase
    end

    always @(posedge clk) begin
        if (alu_start) n_start++;
        n_rsp += $countones(rsp_valid);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int unsigned p, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
        req_a[32*p +: 32] = a;
        req_b[32*p +: 32] = b;
        req_op[4*p +: 4]  = op;
        req_valid[p]      = 1'b1;
    endtask

    task automatic wait_ready(input int unsigned limit);
        int unsigned n = 0;
        while (req_ready == '0 && n < limit) begin
            step();
            n++;
        end
        check("ready_seen", 32'(req_ready != '0), 32'd1);
    endtask

    // Returns cycles counted from the ISSUE cycle (= 1) to the RESP cycle.
    task automatic wait_rsp(input int unsigned limit, output int unsigned lat);
        lat = 1;
        while (rsp_valid == '0 && lat < limit) begin
            step();
            lat++;
        end
        check("rsp_seen", 32'(rsp_valid != '0), 32'd1);
    endtask

    initial begin
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_res = '{32'h0000_E000, 32'hFFFF_E000, 32'h0000_C000, 32'h0000_8000, 32'h0000_E000};

        // Reset state
        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_start", 32'(alu_start), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_result", rsp_result, 32'd0);
        reset = 1'b0;

        // Single request: 1.5 + 2.0
        set_req(0, 32'h0000_6000, 32'h0000_8000, OpAdd);
        #1;
        check("t1_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        check("t1_start", 32'(alu_start), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ready_busy", 32'(req_ready), 32'd0);
        check("t1_alu_a", alu_a, 32'h0000_6000);
        check("t1_alu_b", alu_b, 32'h0000_8000);
        check("t1_alu_op", 32'(alu_op), 32'(OpAdd));
        wait_rsp(20, cyc);
        check("t1_latency", cyc, AluLat + 2);
        check("t1_rsp_port", 32'(rsp_valid), 32'b0001);
        check("t1_result", rsp_result, 32'h0000_E000);
        check("t1_flags", {28'd0, rsp_overflow, rsp_underflow, rsp_div_by_zero, rsp_timeout},
              32'd0);
        step();
        check("t1_rsp_pulse", 32'(rsp_valid), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_hold", rsp_result, 32'h0000_E000);

        // Fairness: all four ports request continuously from rr_ptr = 0
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(0, 32'h0000_6000, 32'h0000_8000, OpAdd);
        set_req(1, 32'h0000_6000, 32'h0000_8000, OpSub);
        set_req(2, 32'h0000_6000, 32'h0000_8000, OpMul);
        set_req(3, 32'h0000_6000, 32'h0000_8000, OpMax);
        #1;
        for (int g = 0; g < 5; g++) begin
            wait_ready(10);
            check($sformatf("t2_grant%0d", g), 32'(req_ready), 32'(exp_gnt[g]));
            step();
            if (g == 4) req_valid = '0;
            wait_rsp(20, cyc);
            check($sformatf("t2_rsp_port%0d", g), 32'(rsp_valid), 32'(exp_gnt[g]));
            check($sformatf("t2_result%0d", g), rsp_result, exp_res[g]);
        end

        // Divide by zero on port 2
        set_req(2, 32'h0000_6000, 32'h0000_0000, OpDiv);
        #1;
        wait_ready(10);
        check("t3_grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        wait_rsp(20, cyc);
        check("t3_rsp_port", 32'(rsp_valid), 32'b0100);
        check("t3_dbz", 32'(rsp_div_by_zero), 32'd1);
        check("t3_result", rsp_result, 32'd0);

        // Reset while in WAIT; rr_ptr was 3 before reset
        set_req(2, 32'h0000_4000, 32'h0000_4000, OpAdd);
        #1;
        wait_ready(10);
        step();
        req_valid = '0;
        step();
        check("t4_busy_wait", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t4_alu_a", alu_a, 32'd0);
        check("t4_result", rsp_result, 32'd0);
        reset = 1'b0;
        // Port 3 also requests, then withdraws without being granted
        set_req(1, 32'h0000_6000, 32'h0000_8000, OpAdd);
        set_req(3, 32'h0000_1234, 32'h0000_4000, OpSub);
        #1;
        check("t4_ptr_zero", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        wait_rsp(20, cyc);
        check("t4_rsp_port", 32'(rsp_valid), 32'b0010);
        check("t4_rsp_result", rsp_result, 32'h0000_E000);
        repeat (AluLat + 4) step();

        // Stray done in IDLE
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_hold", rsp_result, 32'h0000_E000);
        step();
        check("t5_busy2", 32'(busy), 32'd0);
        check("t5_rsp_valid2", 32'(rsp_valid), 32'd0);

`ifdef FIXED_ALU_ARB_TIMEOUT_EN
        // Watchdog: stub never completes
        stub_en = 1'b0;
        set_req(0, 32'h0000_6000, 32'h0000_8000, OpAdd);
        #1;
        wait_ready(10);
        step();
        req_valid = '0;
        wait_rsp(40, cyc);
        check("t6_latency", cyc, TimeoutCycles + 2);
        check("t6_rsp_port", 32'(rsp_valid), 32'b0001);
        check("t6_timeout", 32'(rsp_timeout), 32'd1);
        check("t6_result", rsp_result, 32'd0);
        stub_en = 1'b1;
        repeat (2) step();
        check("t6_starts", 32'(n_start), 32'd10);
        check("t6_rsps", 32'(n_rsp), 32'd9);
`else
        check("t6_starts", 32'(n_start), 32'd9);
        check("t6_rsps", 32'(n_rsp), 32'd8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_alu_arbiter.md
# fixed_alu_arbiter

Round-robin arbiter and sequencer that shares one `fixed_alu` instance between `NUM_REQ` requesters. Each requester independently presents a Q18.14 operation (operands plus a 4-bit `OP_*` code from `alu_defines.v`). The arbiter grants one requester and holds registered operands stable on the ALU for the whole operation. It drives the ALU start pulse, captures result and flags on the ALU's done pulse, and routes them back to the granted requester. It sits between the calculator command front-end and the fixed-point ALU.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 64: watchdog limit in WAIT. Used only with `FIXED_ALU_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: request pending, one bit per requester.
- `req_ready`  out  NUM_REQ: one-hot grant. A request is accepted on an edge where `req_valid[i] && req_ready[i]`.
- `req_a`, `req_b`  in  32*NUM_REQ: Q18.14 operands. Requester i uses bits `[32*i+31:32*i]`.
- `req_op`  in  4*NUM_REQ: operation code. Requester i uses bits `[4*i+3:4*i]`.
- `rsp_valid`  out  NUM_REQ: one-cycle response pulse to the owning requester.
- `rsp_result`  out  32: result, valid while any `rsp_valid` is high.
- `rsp_overflow`, `rsp_underflow`, `rsp_div_by_zero`, `rsp_timeout`  out  1 each: status flags, qualified by `rsp_valid`.
- `busy`  out  1: high in every state except IDLE.
- `alu_a`, `alu_b`  out  32: registered operands to the ALU.
- `alu_op`  out  4: registered operation code to the ALU.
- `alu_start`  out  1: one-cycle start pulse to the ALU.
- `alu_result`  in  32: ALU result.
- `alu_done`, `alu_overflow`, `alu_underflow`, `alu_div_by_zero`  in  1 each: ALU completion pulse and flags.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - `req_ready` is combinational: one-hot on the first requester with `req_valid` set, searching upward from `rr_ptr` and wrapping modulo NUM_REQ.
  - `req_ready` is all zeros when no request is valid.
  - On acceptance: latch a/b/op into `alu_a`/`alu_b`/`alu_op`, record the grant index, set `rr_ptr` to grant+1 (wrapping), and go to ISSUE.
- **ISSUE:** `alu_start`=1 for exactly this cycle, then WAIT.
- **WAIT:**
  - Hold `alu_a`/`alu_b`/`alu_op` stable.
  - On `alu_done`=1: capture `alu_result` and the three ALU flags, then go to RESP.
- **RESP:**
  - Assert `rsp_valid[grant]` for one cycle, with the captured result and flags on the rsp_* outputs.
  - Next state is IDLE. A new grant is possible in the cycle after RESP.
- **Response rules:** no backpressure on responses; the requester must accept in the RESP cycle. `rsp_result` and the flags hold their last value until the next capture.
- **Request rules:**
  - A requester keeps `req_valid` and its fields stable until accepted.
  - Deasserting `req_valid` before acceptance withdraws the request.
- **Stray done:** `alu_done` in IDLE, ISSUE or RESP is ignored.
- **Fairness:** round-robin guarantees a continuously requesting port waits at most NUM_REQ-1 operations.
- **Reset:** on `reset`=1 at an edge, regardless of state:
  - state becomes IDLE and `rr_ptr`=0;
  - `alu_a`, `alu_b` and `rsp_result` become 0; `alu_op` becomes 0;
  - `alu_start`, `rsp_valid`, all `rsp_*` flags and `busy` become 0.
- **Reset of the ALU:** the ALU shares the same `reset`. An operation in flight at reset is discarded and never produces a response.

## Timing
- Acceptance edge E: ISSUE during cycle E+1, with `alu_start` high.
- WAIT from E+2 until the edge sampling `alu_done`=1 (edge D); RESP during cycle D+1.
- Request-to-response latency = ALU latency + 2 cycles. Throughput is one operation per (latency + 3) cycles.
- `req_ready` is zero in every state except IDLE.
- `alu_a`, `alu_b` and `alu_op` change only on acceptance edges and on reset.

## Configuration
- Macro: `FIXED_ALU_ARB_TIMEOUT_EN`.
- **Defined:**
  - WAIT runs a cycle counter cleared on entry to WAIT.
  - If the counter reaches `TIMEOUT_CYCLES` without `alu_done`, go to RESP with `rsp_timeout`=1, `rsp_result`=0 and the other flags 0.
  - If `alu_done` and the limit occur in the same cycle, done wins and `rsp_timeout`=0.
- **Undefined:** no counter; WAIT waits indefinitely; `rsp_timeout` is tied to 0.

## Test plan
- **Single request:** req 0, a=0x00006000 (1.5), b=0x00008000 (2.0), op=`OP_ADD`. Expect one `alu_start` pulse, then `rsp_valid[0]` with `rsp_result`=0x0000E000 and all flags 0. Measured latency = ALU latency + 2.
- **Fairness:** all 4 ports continuously valid, each with a distinct op on 1.5 and 2.0 (ADD/SUB/MUL/MAX). Grants occur in order 0,1,2,3,0. Results: 0x0000E000, 0xFFFFE000, 0x0000C000, 0x00008000.
- **Divide by zero:** req 2, `OP_DIV`, b=0. Expect `rsp_valid[2]` with `rsp_div_by_zero`=1. `rsp_valid` never fires on other ports.
- **Reset mid-operation:** `reset` asserted in WAIT. Next cycle: `busy`=0, `rr_ptr`=0, no `rsp_valid`. Then a fresh request to port 1 completes normally.
- **Withdrawn request and stray done:** port 3 drops `req_valid` before grant and receives no response. `alu_done` forced high in IDLE: no state change.
- **Timeout (macro defined, TIMEOUT_CYCLES=8):** ALU stub never raises done. `rsp_valid` fires with `rsp_timeout`=1 and result 0, 8 cycles after entering WAIT.
